// File: rtl/seg14_pkg.sv
// seg14 shared definitions: character codes, 14-segment glyphs, decoder.
// Segment order, MSB first: a b c d e f g1 g2 h i j k l m.
package seg14_pkg;

  typedef enum logic [5:0] {
    CH_SPACE,
    CH_A, CH_B, CH_C, CH_D, CH_E, CH_F, CH_G,
    CH_H, CH_I, CH_J, CH_K, CH_L, CH_M, CH_N,
    CH_O, CH_P, CH_Q, CH_R, CH_S, CH_T, CH_U,
    CH_V, CH_W, CH_X, CH_Y, CH_Z,
    CH_0, CH_1, CH_2, CH_3, CH_4,
    CH_5, CH_6, CH_7, CH_8, CH_9
  } char_e;

  localparam logic [13:0] G_SPACE = 14'b00000000000000;
  localparam logic [13:0] G_A = 14'b11101111000000;
  localparam logic [13:0] G_B = 14'b11110001010010;
  localparam logic [13:0] G_C = 14'b10011100000000;
  localparam logic [13:0] G_D = 14'b11110000010010;
  localparam logic [13:0] G_E = 14'b10011110000000;
  localparam logic [13:0] G_F = 14'b10001110000000;
  localparam logic [13:0] G_G = 14'b10111101000000;
  localparam logic [13:0] G_H = 14'b01101111000000;
  localparam logic [13:0] G_I = 14'b10010000010010;
  localparam logic [13:0] G_J = 14'b01111000000000;
  localparam logic [13:0] G_K = 14'b00001110001100;
  localparam logic [13:0] G_L = 14'b00011100000000;
  localparam logic [13:0] G_M = 14'b01101100101000;
  localparam logic [13:0] G_N = 14'b01101100100100;
  localparam logic [13:0] G_O = 14'b11111100000000;
  localparam logic [13:0] G_P = 14'b11001111000000;
  localparam logic [13:0] G_Q = 14'b11111100000100;
  localparam logic [13:0] G_R = 14'b11001111000100;
  localparam logic [13:0] G_S = 14'b10110111000000;
  localparam logic [13:0] G_T = 14'b10000000010010;
  localparam logic [13:0] G_U = 14'b01111100000000;
  localparam logic [13:0] G_V = 14'b00001100001001;
  localparam logic [13:0] G_W = 14'b01101100000101;
  localparam logic [13:0] G_X = 14'b00000000101101;
  localparam logic [13:0] G_Y = 14'b00000000101010;
  localparam logic [13:0] G_Z = 14'b10010000001001;
  localparam logic [13:0] G_0 = 14'b11111100001001;
  localparam logic [13:0] G_1 = 14'b01100000001000;
  localparam logic [13:0] G_2 = 14'b11011011000000;
  localparam logic [13:0] G_3 = 14'b11110001000000;
  localparam logic [13:0] G_4 = 14'b01100111000000;
  localparam logic [13:0] G_5 = 14'b10110111000000;
  localparam logic [13:0] G_6 = 14'b10111111000000;
  localparam logic [13:0] G_7 = 14'b11100000000000;
  localparam logic [13:0] G_8 = 14'b11111111000000;
  localparam logic [13:0] G_9 = 14'b11110111000000;

  // Codes 37..63 fall through to the blank glyph.
  function automatic logic [13:0] glyph(input logic [5:0] code);
    logic [13:0] g;
    case (char_e'(code))
      CH_A: g = G_A;
      CH_B: g = G_B;
      CH_C: g = G_C;
      CH_D: g = G_D;
      CH_E: g = G_E;
      CH_F: g = G_F;
      CH_G: g = G_G;
      CH_H: g = G_H;
      CH_I: g = G_I;
      CH_J: g = G_J;
      CH_K: g = G_K;
      CH_L: g = G_L;
      CH_M: g = G_M;
      CH_N: g = G_N;
      CH_O: g = G_O;
      CH_P: g = G_P;
      CH_Q: g = G_Q;
      CH_R: g = G_R;
      CH_S: g = G_S;
      CH_T: g = G_T;
      CH_U: g = G_U;
      CH_V: g = G_V;
      CH_W: g = G_W;
      CH_X: g = G_X;
      CH_Y: g = G_Y;
      CH_Z: g = G_Z;
      CH_0: g = G_0;
      CH_1: g = G_1;
      CH_2: g = G_2;
      CH_3: g = G_3;
      CH_4: g = G_4;
      CH_5: g = G_5;
      CH_6: g = G_6;
      CH_7: g = G_7;
      CH_8: g = G_8;
      CH_9: g = G_9;
      default: g = G_SPACE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg14_scan_timer.sv
// seg14 scan timing: slot divider, digit index, frame tick, scroll pacing.
// Ports: enable_i/scroll_i in; slot_tick_o, d_o, frame_tick_o, scroll_step_o out.
module seg14_scan_timer #(
  parameter int N_DIGITS = 12,
  parameter int SCAN_DIV = 1,
  parameter int SCROLL_DIV = 64,
  localparam int DW = $clog2(N_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_i,
  input  logic          scroll_i,
  output logic          slot_tick_o,
  output logic [DW-1:0] d_o,
  output logic          frame_tick_o,
  output logic          scroll_step_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(N_DIGITS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(SCROLL_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic [DW-1:0] d_q, d_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          ft_q;
  logic          frame_end;

  always_comb begin
    slot_tick_o = enable_i && (div_q == DIV_LAST);
    frame_end = slot_tick_o && (d_q == D_LAST);
    scroll_step_o = frame_end && scroll_i && (fcnt_q == F_LAST);

    div_d = div_q;
    if (enable_i) begin
      div_d = slot_tick_o ? '0 : div_q + CW'(1);
    end

    d_d = d_q;
    if (slot_tick_o) begin
      d_d = frame_end ? '0 : d_q + DW'(1);
    end

    // Frames only count while scrolling; leaving scroll mode restarts pacing.
    fcnt_d = fcnt_q;
    if (!scroll_i) begin
      fcnt_d = '0;
    end else if (frame_end) begin
      fcnt_d = scroll_step_o ? '0 : fcnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      d_q <= '0;
      fcnt_q <= '0;
      ft_q <= 1'b0;
    end else begin
      div_q <= div_d;
      d_q <= d_d;
      fcnt_q <= fcnt_d;
      ft_q <= frame_end;
    end
  end

  assign d_o = d_q;
  assign frame_tick_o = ft_q;

endmodule

// File: rtl/seg14_scroll_mux.sv
// seg14 multiplexed 14-segment driver with static and marquee modes.
// Ports: message write port, mode controls in; one-hot sel, segm, frame_tick out.
module seg14_scroll_mux
  import seg14_pkg::*;
#(
  parameter int N_DIGITS = 12,
  parameter int MSG_DEPTH = 32,
  parameter int SCAN_DIV = 1,
  parameter int SCROLL_DIV = 64,
  localparam int AW = $clog2(MSG_DEPTH),
  localparam int DW = $clog2(N_DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                scroll,
  input  logic [AW:0]         msg_len,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [5:0]          wr_char,
  output logic [N_DIGITS-1:0] sel,
  output logic [13:0]         segm,
  output logic                frame_tick
);

  logic          slot_tick;
  logic [DW-1:0] d;
  logic          scroll_step;
  logic          frame_end;

  logic [5:0]    mem_q [MSG_DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] off_q, off_d;
  logic [AW:0]   ptr_inc, off_inc;
  logic [AW-1:0] rd_idx;
  logic          show;
  logic [13:0]   glyph_w;

  logic [N_DIGITS-1:0] sel_q, sel_d;
  logic [13:0]         segm_q, segm_d;

  seg14_scan_timer #(
    .N_DIGITS  (N_DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .SCROLL_DIV(SCROLL_DIV)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .scroll_i     (scroll),
    .slot_tick_o  (slot_tick),
    .d_o          (d),
    .frame_tick_o (frame_tick),
    .scroll_step_o(scroll_step)
  );

  // Pointers wrap by compare against msg_len, so no modulo is needed.
  always_comb begin
    frame_end = slot_tick && (d == DW'(N_DIGITS - 1));
    ptr_inc = {1'b0, ptr_q} + (AW+1)'(1);
    off_inc = {1'b0, off_q} + (AW+1)'(1);

    off_d = off_q;
    if (!scroll) begin
      off_d = '0;
    end else if (scroll_step) begin
      off_d = (off_inc >= msg_len) ? '0 : off_inc[AW-1:0];
    end else if (frame_end && ({1'b0, off_q} >= msg_len)) begin
      off_d = '0;
    end

    // The next frame starts at the offset that takes effect this edge.
    ptr_d = ptr_q;
    if (slot_tick) begin
      if (frame_end) begin
        ptr_d = off_d;
      end else begin
        ptr_d = (ptr_inc >= msg_len) ? '0 : ptr_inc[AW-1:0];
      end
    end
  end

  // Reads see the pre-edge buffer, so a same-cycle write shows next scan.
  always_comb begin
    rd_idx = scroll ? ptr_q : AW'(d);
    show = (msg_len != '0) && (scroll || ((AW+1)'(d) < msg_len));
    glyph_w = show ? glyph(mem_q[rd_idx]) : G_SPACE;

    sel_d = '0;
    segm_d = '0;
    if (enable) begin
      sel_d = N_DIGITS'(1) << d;
      segm_d = glyph_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_char;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      off_q <= '0;
      sel_q <= '0;
      segm_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      off_q <= off_d;
      sel_q <= sel_d;
      segm_q <= segm_d;
    end
  end

  assign sel = sel_q;
  assign segm = segm_q;

endmodule

// File: doc/seg14_scroll_mux.md
# seg14_scroll_mux

Parametrised 14-segment multiplexed display driver. It scans `N_DIGITS` common-select lines and drives one glyph at a time from a writable message buffer of up to `MSG_DEPTH` character codes. Each character code is decoded to a 14-segment pattern. The block supports a static mode and a scrolling marquee mode, and sits between the user-area logic that writes the message and the display pads.

## Interface
Parameters:
- `N_DIGITS`, default 12: number of digits and width of `sel`; must be at least 2.
- `MSG_DEPTH`, default 32: message buffer entries; must be a power of 2 and at least `N_DIGITS`.
- `SCAN_DIV`, default 1: clocks per digit slot; must be at least 1.
- `SCROLL_DIV`, default 64: full scan frames per scroll step; must be at least 1.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: 0 blanks the display and freezes the scan.
- `scroll`, input, 1: 0 selects static mode, 1 selects scroll mode.
- `msg_len`, input, log2(`MSG_DEPTH`)+1 bits: number of valid characters, from 0 to `MSG_DEPTH`.
- `wr_en`, input, 1: message write strobe.
- `wr_addr`, input, log2(`MSG_DEPTH`) bits: write address.
- `wr_char`, input, 6: character code to write.
- `sel`, output, `N_DIGITS` bits: one-hot digit select, registered.
- `segm`, output, 14: segment pattern, registered. Bit 13 is segment a.
- `frame_tick`, output, 1: one-clock pulse when digit `N_DIGITS`-1 has finished its slot.

## Operation
- **Character codes:** 0 is space (all segments 0); 1–26 are A–Z; 27–36 are 0–9; 37–63 decode to space.
  - Glyph patterns: L=`00011100000000`, U=`01111100000000`, I=`10010000010010`, S=`10110111000000`, A=`11101111000000`, B=`11110001010010`, E=`10011110000000`, R=`11001111000100`, T=`10000000010010`, O=`11111100000000`.
- **Message buffer:** a register array of `MSG_DEPTH` entries × 6 bits, reset to all 0. A write occurs on any cycle with `wr_en`=1.
- **Slot divider:** `div` counts 0..`SCAN_DIV`-1. The last count is the slot tick.
  - On a slot tick, digit index `d` advances and wraps from `N_DIGITS`-1 to 0.
  - `frame_tick` pulses on the tick where `d` wraps.
- **Character pointer `ptr`:** reloaded with `offset` at each frame start (`d`=0). It then increments once per slot and wraps from `msg_len`-1 to 0. No modulo hardware is used.
- **Static mode:** `offset` is held at 0. Digit `d` shows entry `d` when `d` < `msg_len`, otherwise it shows space.
- **Scroll mode:** digit `d` shows entry `ptr`.
  - A frame counter counts to `SCROLL_DIV`. On its terminal count, at the frame boundary, `offset` increments and wraps from `msg_len`-1 to 0.
  - When `msg_len` < `N_DIGITS`, the message repeats across the digits.
- **`msg_len`=0:** every digit shows space, in both modes.
- **`msg_len` change:** if `offset` ≥ the new `msg_len`, `offset` is cleared at the next frame boundary.
- **`scroll` 1→0:** `offset` and the frame counter clear on the next clock edge.
- **`enable`=0:** `sel`=0 and `segm`=0 from the next edge. `div`, `d`, `ptr`, `offset` and the frame counter hold. Writes still occur.
- **Simultaneous write and read of the same address:** the registered output takes the old value. The new value is shown the next time that entry is scanned.

## Timing
- Reset values: `sel`=0, `segm`=0, `frame_tick`=0, `div`=`d`=`ptr`=`offset`=0, frame counter=0, message buffer all 0.
- After `rst` is released with `enable`=1, the first edge loads `sel`=1 (digit 0) and `segm`=glyph(entry 0).
- Output latency is one clock from an index update to `sel`/`segm`. `sel` and `segm` change on the same edge, so `sel` is never multi-hot.
- Each digit is held for `SCAN_DIV` clocks. A frame is `N_DIGITS`×`SCAN_DIV` clocks.
- A scroll step occurs every `SCROLL_DIV` frames.
- Reset asserted mid-frame forces every output to 0 immediately (asynchronous), and all state restarts at digit 0.

## Structure
- Package `seg14_pkg` holds:
  - the 6-bit character-code constants;
  - the 14-bit glyph constants;
  - the function `glyph(code)`, which returns the 14-bit pattern.
- Sub-module `seg14_scan_timer` holds the slot divider, digit index, `frame_tick` and the frame counter. It outputs `slot_tick`, `d`, `frame_tick` and `scroll_step`.
- The top level holds the message buffer, `ptr`/`offset` logic, glyph decode and output registers.

## Test plan
- **Static message:** `N_DIGITS`=12, `SCAN_DIV`=1. Write "LUIS ALBERTO" as codes 12,21,9,19,0,1,12,2,5,18,20,15 and set `msg_len`=12, `scroll`=0.
  - Required: `sel` walks 1,2,4..0x800. `segm` matches the glyphs, e.g. `sel`=0x001 → `00011100000000` and `sel`=0x800 → `11111100000000`.
  - Required: `frame_tick` pulses once every 12 clocks.
- **`SCAN_DIV`=3:** each `sel` value is held for exactly 3 clocks, and `frame_tick` has a period of 36 clocks.
- **Scroll:** `scroll`=1, `SCROLL_DIV`=2, `msg_len`=14.
  - Required: after 2 frames, digit 0 shows entry 1.
  - Required: after 28 frames, `offset` has wrapped to 0 and digit 0 shows entry 0.
- **Short message:** `msg_len`=3 with "ABC" in scroll mode → digits show A,B,C,A,B,C,... `msg_len`=0 → `segm`=0 on every slot.
- **Boundaries:** writing entry 5 while digit 5 is being displayed gives the old glyph in the current frame and the new glyph in the next frame.
  - `enable`=0 for 10 clocks → `sel`=0, then the scan resumes at the same digit.
  - `rst` asserted mid-frame → `sel`=`segm`=0 immediately.
